// File: rtl/seg_display_mux.sv
// rtl/seg_display_mux.sv - time-multiplexed seven-segment driver with double-dabble BCD
// Captures a selected register, converts it (decimal) or passes it through (hex), and scans digits.
module seg_display_mux #(
   parameter int NUM_REGS    = 9,
   parameter int DATA_W      = 32,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_LZ    = 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_REGS*DATA_W-1:0] reg_data,
   input  logic [3:0]                 SW,
   input  logic                       hex_mode,
   output logic [6:0]                 SEG,
   output logic                       DP,
   output logic [DIGITS-1:0]          AN,
   output logic                       busy
);

   localparam int NIB = (DATA_W + 2) / 3 + 1;
   localparam int BW  = 4 * NIB;
   localparam int XW  = (BW > 4 * DIGITS) ? BW : 4 * DIGITS;
   localparam int CW  = $clog2(DATA_W + 1);
   localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONVERT, S_UPDATE} state_t;

   state_t                   state;
   logic [DATA_W-1:0]        shift_val;
   logic [BW-1:0]            bcd;
   logic                     mode_hex;
   logic [CW-1:0]            conv_cnt;
   logic [DIGITS-1:0][6:0]   disp_buf;
   logic [RW-1:0]            ref_cnt;
   logic [IW-1:0]            digit_idx;

   logic [DATA_W-1:0]        sel_val;
   logic [BW-1:0]            bcd_adj;
   logic [XW-1:0]            src;
   logic                     ovf;
   logic                     lead;
   logic [3:0]               nib;
   logic [DIGITS-1:0][6:0]   new_buf;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'h0: glyph = 7'b1000000;
         4'h1: glyph = 7'b1111001;
         4'h2: glyph = 7'b0100100;
         4'h3: glyph = 7'b0110000;
         4'h4: glyph = 7'b0011001;
         4'h5: glyph = 7'b0010010;
         4'h6: glyph = 7'b0000010;
         4'h7: glyph = 7'b1111000;
         4'h8: glyph = 7'b0000000;
         4'h9: glyph = 7'b0010000;
         4'hA: glyph = 7'b0001000;
         4'hB: glyph = 7'b0000011;
         4'hC: glyph = 7'b1000110;
         4'hD: glyph = 7'b0100001;
         4'hE: glyph = 7'b0000110;
         default: glyph = 7'b0001110;
      endcase
   endfunction

   // Unlisted switch codes (0, above NUM_REGS) display constant zero.
   always_comb begin
      sel_val = '0;
      for (int k = 1; k <= NUM_REGS; k++) begin
         if (SW == 4'(k)) sel_val = reg_data[(k-1)*DATA_W +: DATA_W];
      end
   end

   always_comb begin
      bcd_adj = bcd;
      for (int i = 0; i < NIB; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
   end

   // Scan from the most significant digit down so leading zeros can be tracked in one pass.
   always_comb begin
      src     = mode_hex ? XW'(shift_val) : XW'(bcd);
      ovf     = |(src >> (4 * DIGITS));
      lead    = 1'b1;
      nib     = 4'd0;
      new_buf = {DIGITS{7'h7F}};
      for (int i = DIGITS - 1; i >= 0; i--) begin
         nib = src[4*i +: 4];
         if (nib != 4'd0) lead = 1'b0;
         if (ovf)
            new_buf[i] = 7'b0111111;
         else if ((BLANK_LZ != 0) && lead && (i != 0))
            new_buf[i] = 7'h7F;
         else
            new_buf[i] = glyph(nib);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= S_IDLE;
         busy      <= 1'b0;
         shift_val <= '0;
         bcd       <= '0;
         mode_hex  <= 1'b0;
         conv_cnt  <= '0;
         disp_buf  <= {DIGITS{7'h7F}};
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_LOAD;
               busy  <= 1'b1;
            end
            S_LOAD: begin
               shift_val <= sel_val;
               mode_hex  <= hex_mode;
               bcd       <= '0;
               conv_cnt  <= '0;
               state     <= hex_mode ? S_UPDATE : S_CONVERT;
            end
            S_CONVERT: begin
               {bcd, shift_val} <= {bcd_adj, shift_val} << 1;
               conv_cnt         <= conv_cnt + 1'b1;
               if (conv_cnt == CW'(DATA_W - 1)) state <= S_UPDATE;
            end
            S_UPDATE: begin
               disp_buf <= new_buf;
               state    <= S_IDLE;
               busy     <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         ref_cnt   <= '0;
         digit_idx <= '0;
         AN        <= '1;
         SEG       <= 7'h7F;
      end else begin
         if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
            ref_cnt   <= '0;
            digit_idx <= (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + 1'b1;
         end else begin
            ref_cnt <= ref_cnt + 1'b1;
         end
         AN  <= ~(DIGITS'(1) << digit_idx);
         SEG <= disp_buf[digit_idx];
      end
   end

   assign DP = 1'b1;

endmodule
